// File: rtl/video_pkg.sv
// Shared types and constants for the video post-processing path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package video_pkg;

    typedef enum logic [1:0] {
        SCAN_OFF = 2'd0,
        SCAN_25  = 2'd1,
        SCAN_50  = 2'd2,
        SCAN_75  = 2'd3
    } scan_mode_t;

    localparam int LINE_CNT_W = 12;

endpackage

// File: rtl/scanline_attenuate.sv
// Per-channel colour attenuator: unsigned, truncating shifts.
// Latency: combinational.
// Backpressure: none.
module scanline_attenuate
    import video_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] x,
    input  scan_mode_t    mode,
    output logic [DW-1:0] y
);

    always_comb begin
        y = x;
        case (mode)
            SCAN_25: y = x - (x >> 2);
            SCAN_50: y = x >> 1;
            SCAN_75: y = x >> 2;
            default: y = x;
        endcase
    end

endmodule

// File: rtl/video_scanlines.sv
// CRT scanline emulation: dims alternate active lines, keeps sync/blank aligned.
// Latency: 2 clocks for colour and control, no bubbles.
// Backpressure: none (streaming pixel path). Option: VIDEO_SCANLINE_FIELD_TOGGLE_EN.
module video_scanlines
    import video_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] r_in,
    input  logic [DW-1:0] g_in,
    input  logic [DW-1:0] b_in,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          de_in,
    input  logic          hb_in,
    input  logic          vb_in,
    output logic [DW-1:0] r_out,
    output logic [DW-1:0] g_out,
    output logic [DW-1:0] b_out,
    output logic          hs_out,
    output logic          vs_out,
    output logic          de_out,
    output logic          hb_out,
    output logic          vb_out
);

    logic                  hs_prev_q, hs_prev_d;
    logic                  vs_prev_q, vs_prev_d;
    logic                  vb_prev_q, vb_prev_d;
    scan_mode_t            mode_q, mode_d;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic                  tgt;

`ifdef VIDEO_SCANLINE_FIELD_TOGGLE_EN
    logic                  tgt_q, tgt_d;
    assign tgt = tgt_q;
`else
    assign tgt = 1'b1;
`endif

    // Stage 1
    logic [DW-1:0] s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d;
    logic          s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_de_q, s1_de_d;
    logic          s1_hb_q, s1_hb_d, s1_vb_q, s1_vb_d;
    logic          s1_dark_q, s1_dark_d;
    scan_mode_t    s1_mode_q, s1_mode_d;

    // Stage 2
    logic [DW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, hb_q, hb_d, vb_q, vb_d;

    logic          hs_rise, vs_rise, vb_fall, odd;
    scan_mode_t    att_mode;
    logic [DW-1:0] r_att, g_att, b_att;

    // The line counter's LSB is the parity; once saturated the parity freezes.
    assign odd      = line_cnt_q[0];
    assign att_mode = s1_dark_q ? s1_mode_q : SCAN_OFF;

    scanline_attenuate #(.DW(DW)) u_att_r (.x(s1_r_q), .mode(att_mode), .y(r_att));
    scanline_attenuate #(.DW(DW)) u_att_g (.x(s1_g_q), .mode(att_mode), .y(g_att));
    scanline_attenuate #(.DW(DW)) u_att_b (.x(s1_b_q), .mode(att_mode), .y(b_att));

    always_comb begin
        hs_rise   = hs_in & ~hs_prev_q;
        vs_rise   = vs_in & ~vs_prev_q;
        vb_fall   = ~vb_in & vb_prev_q;
        hs_prev_d = hs_in;
        vs_prev_d = vs_in;
        vb_prev_d = vb_in;

        mode_d = vs_rise ? scan_mode_t'(mode) : mode_q;
`ifdef VIDEO_SCANLINE_FIELD_TOGGLE_EN
        tgt_d  = vs_rise ? ~tgt_q : tgt_q;
`endif

        // A coincident blanking exit beats the hsync toggle: first active line is even.
        line_cnt_d = line_cnt_q;
        if (vb_fall) begin
            line_cnt_d = '0;
        end else if (hs_rise && !vb_in && line_cnt_q != '1) begin
            line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
        end

        s1_r_d    = r_in;
        s1_g_d    = g_in;
        s1_b_d    = b_in;
        s1_hs_d   = hs_in;
        s1_vs_d   = vs_in;
        s1_de_d   = de_in;
        s1_hb_d   = hb_in;
        s1_vb_d   = vb_in;
        s1_dark_d = (mode_q != SCAN_OFF) && (odd == tgt) && de_in;
        s1_mode_d = mode_q;

        r_d  = s1_de_q ? r_att : '0;
        g_d  = s1_de_q ? g_att : '0;
        b_d  = s1_de_q ? b_att : '0;
        hs_d = s1_hs_q;
        vs_d = s1_vs_q;
        de_d = s1_de_q;
        hb_d = s1_hb_q;
        vb_d = s1_vb_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b0;
            vb_prev_q  <= 1'b0;
            mode_q     <= SCAN_OFF;
            line_cnt_q <= '0;
`ifdef VIDEO_SCANLINE_FIELD_TOGGLE_EN
            tgt_q      <= 1'b1;
`endif
            s1_r_q     <= '0;
            s1_g_q     <= '0;
            s1_b_q     <= '0;
            s1_hs_q    <= 1'b0;
            s1_vs_q    <= 1'b0;
            s1_de_q    <= 1'b0;
            s1_hb_q    <= 1'b0;
            s1_vb_q    <= 1'b0;
            s1_dark_q  <= 1'b0;
            s1_mode_q  <= SCAN_OFF;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            de_q       <= 1'b0;
            hb_q       <= 1'b0;
            vb_q       <= 1'b0;
        end else begin
            hs_prev_q  <= hs_prev_d;
            vs_prev_q  <= vs_prev_d;
            vb_prev_q  <= vb_prev_d;
            mode_q     <= mode_d;
            line_cnt_q <= line_cnt_d;
`ifdef VIDEO_SCANLINE_FIELD_TOGGLE_EN
            tgt_q      <= tgt_d;
`endif
            s1_r_q     <= s1_r_d;
            s1_g_q     <= s1_g_d;
            s1_b_q     <= s1_b_d;
            s1_hs_q    <= s1_hs_d;
            s1_vs_q    <= s1_vs_d;
            s1_de_q    <= s1_de_d;
            s1_hb_q    <= s1_hb_d;
            s1_vb_q    <= s1_vb_d;
            s1_dark_q  <= s1_dark_d;
            s1_mode_q  <= s1_mode_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            de_q       <= de_d;
            hb_q       <= hb_d;
            vb_q       <= vb_d;
        end
    end

    assign r_out  = r_q;
    assign g_out  = g_q;
    assign b_out  = b_q;
    assign hs_out = hs_q;
    assign vs_out = vs_q;
    assign de_out = de_q;
    assign hb_out = hb_q;
    assign vb_out = vb_q;

endmodule
